// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: valid/ready word intake into a one-word hold, then MSB-first serialisation
// at DIV clocks per bit with GAP idle bit periods. Define PARITY_EN to append an even-parity bit.
module piso_tx_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done,
    output logic             busy
);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = $clog2(WIDTH);
    localparam int GAP_CYC = GAP * DIV;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
`endif
    localparam logic [1:0] S_GAP   = 2'd3;
    // Where a finished word goes when no back-to-back load happens.
    localparam logic [1:0] S_POST  = (GAP > 0) ? S_GAP : S_IDLE;

    logic [1:0]       state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] shreg;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
`ifdef PARITY_EN
    logic             par_bit;
`endif

    logic accept;
    logic last_tick;
    logic last_bit;
    logic word_end;
    logic gap_end;
    logic load;

    assign accept    = in_valid && !hold_valid;
    assign last_tick = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);
`ifdef PARITY_EN
    assign word_end  = (state == S_PAR) && last_tick;
`else
    assign word_end  = (state == S_SHIFT) && last_tick && last_bit;
`endif
    assign gap_end   = (state == S_GAP) && (gap_cnt == GAP_LAST);
    // With no gap, a held word loads on the last tick so its MSB follows the LSB directly.
    assign load      = hold_valid && ((state == S_IDLE) || gap_end || (word_end && (GAP == 0)));

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
`ifdef PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                hold       <= in_data;
                hold_valid <= 1'b1;
            end
            if (load) begin
                state      <= S_SHIFT;
                shreg      <= hold;
                hold_valid <= 1'b0;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                gap_cnt    <= '0;
`ifdef PARITY_EN
                par_bit    <= ^hold;
`endif
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (last_tick) begin
                            div_cnt <= '0;
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            if (last_bit) begin
                                bit_cnt <= '0;
`ifdef PARITY_EN
                                state   <= S_PAR;
`else
                                state   <= S_POST;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
`ifdef PARITY_EN
                    S_PAR: begin
                        if (last_tick) begin
                            div_cnt <= '0;
                            state   <= S_POST;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
`endif
                    S_GAP: begin
                        if (gap_end) begin
                            gap_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready = !hold_valid;
    assign busy     = (state != S_IDLE) || hold_valid;
    assign done     = word_end;
`ifdef PARITY_EN
    assign frame      = (state == S_SHIFT) || (state == S_PAR);
    assign serial_out = (state == S_SHIFT) ? shreg[WIDTH-1] : ((state == S_PAR) && par_bit);
`else
    assign frame      = (state == S_SHIFT);
    assign serial_out = frame && shreg[WIDTH-1];
`endif

endmodule
